// File: rtl/lcd_byte_writer.sv
// -----------------------------------------------------------------------------
// lcd_byte_writer
//
// Sends one byte to a character LCD over its 4-bit write-only interface. The
// upper nibble goes first, then the lower nibble. Each nibble gets a setup
// period, an LCD_E strobe and a one-cycle hold. A fixed gap separates the two
// nibbles, and the byte ends with a settle wait: short for ordinary commands
// and data, long for clear/home.
//
// Ports
//   Clock                   system clock, rising-edge active
//   Reset                   asynchronous active-low reset
//   iWrite                  byte-transfer request, taken only while oReady=1
//   iRegisterSelect         0 = command register, 1 = data register
//   iData[7:0]              byte to send
//   iLongWait               use LONG_WAIT_CYCLES for this byte's settle wait
//   oReady                  high while a request can be accepted (IDLE)
//   oDone                   one-cycle pulse once the byte and its wait are over
//   oLCD_Enabled            LCD_E strobe
//   oLCD_RegisterSelect     LCD_RS
//   oLCD_Data[3:0]          SF_D<11:8>
//   oLCD_ReadWrite          LCD_RW, tied to write
//   oLCD_StrataFlashControl keeps the shared StrataFlash disabled
// -----------------------------------------------------------------------------
module lcd_byte_writer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int ENABLE_CYCLES     = 12,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int LONG_WAIT_CYCLES  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic       iRegisterSelect,
  input  logic [7:0] iData,
  input  logic       iLongWait,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SETUP_HI = 4'd1,
    PULSE_HI = 4'd2,
    HOLD_HI  = 4'd3,
    GAP      = 4'd4,
    SETUP_LO = 4'd5,
    PULSE_LO = 4'd6,
    HOLD_LO  = 4'd7,
    WAIT     = 4'd8
  } state_t;

  // A timed state ends when the counter reaches these values, so each state
  // lasts exactly its cycle count.
  localparam logic [31:0] SETUP_LAST  = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] ENABLE_LAST = 32'(ENABLE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [31:0] CMD_LAST    = 32'(CMD_WAIT_CYCLES - 1);
  localparam logic [31:0] LONG_LAST   = 32'(LONG_WAIT_CYCLES - 1);

  state_t      state;
  state_t      nextState;
  logic [31:0] count;
  logic [31:0] nextCount;
  logic [31:0] stateLast;
  logic        timeUp;
  logic        accept;

  logic [7:0]  capturedData;
  logic        capturedRs;
  logic        capturedLong;
  logic [7:0]  nextCapturedData;
  logic        nextCapturedRs;
  logic        nextCapturedLong;

  logic        nextReady;
  logic        nextDone;
  logic        nextEnable;
  logic        nextRs;
  logic [3:0]  nextData;

  // The LCD is only ever written, and the StrataFlash on the shared bus stays off.
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // oReady is registered as (state == IDLE), so it also serves as the accept qualifier.
  assign accept = iWrite & oReady;
  assign timeUp = (count == stateLast);

  // Final counter value of the current state.
  always_comb begin
    stateLast = 32'd0;
    case (state)
      SETUP_HI, SETUP_LO: stateLast = SETUP_LAST;
      PULSE_HI, PULSE_LO: stateLast = ENABLE_LAST;
      HOLD_HI, HOLD_LO:   stateLast = 32'd0;
      GAP:                stateLast = GAP_LAST;
      WAIT:               stateLast = capturedLong ? LONG_LAST : CMD_LAST;
      default:            stateLast = 32'd0;
    endcase
  end

  // Next-state logic for the nibble sequencer.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) nextState = SETUP_HI;
        else        nextState = IDLE;
      end
      SETUP_HI: begin
        if (timeUp) nextState = PULSE_HI;
        else        nextState = SETUP_HI;
      end
      PULSE_HI: begin
        if (timeUp) nextState = HOLD_HI;
        else        nextState = PULSE_HI;
      end
      HOLD_HI: begin
        if (timeUp) nextState = GAP;
        else        nextState = HOLD_HI;
      end
      GAP: begin
        if (timeUp) nextState = SETUP_LO;
        else        nextState = GAP;
      end
      SETUP_LO: begin
        if (timeUp) nextState = PULSE_LO;
        else        nextState = SETUP_LO;
      end
      PULSE_LO: begin
        if (timeUp) nextState = HOLD_LO;
        else        nextState = PULSE_LO;
      end
      HOLD_LO: begin
        if (timeUp) nextState = WAIT;
        else        nextState = HOLD_LO;
      end
      WAIT: begin
        if (timeUp) nextState = IDLE;
        else        nextState = WAIT;
      end
      default: nextState = IDLE;
    endcase
  end

  // Cycle counter: restarts at every state change and stays at zero in IDLE.
  always_comb begin
    nextCount = 32'd0;
    if (nextState != state) begin
      nextCount = 32'd0;
    end else if (state == IDLE) begin
      nextCount = 32'd0;
    end else begin
      nextCount = count + 32'd1;
    end
  end

  // Capture the request on the accept edge. Later input changes are ignored.
  always_comb begin
    nextCapturedData = capturedData;
    nextCapturedRs   = capturedRs;
    nextCapturedLong = capturedLong;
    if (accept) begin
      nextCapturedData = iData;
      nextCapturedRs   = iRegisterSelect;
      nextCapturedLong = iLongWait;
    end else begin
      nextCapturedData = capturedData;
      nextCapturedRs   = capturedRs;
      nextCapturedLong = capturedLong;
    end
  end

  // Output values for the state being entered. They are decoded from the
  // next state and next capture, so the registered pins line up with the
  // state register and the accept edge already shows the upper nibble.
  always_comb begin
    nextReady  = 1'b0;
    nextDone   = 1'b0;
    nextEnable = 1'b0;
    nextRs     = 1'b0;
    nextData   = 4'h0;
    case (nextState)
      IDLE: begin
        nextReady = 1'b1;
        nextDone  = (state == WAIT) ? 1'b1 : 1'b0;
      end
      SETUP_HI, HOLD_HI, GAP: begin
        nextRs   = nextCapturedRs;
        nextData = nextCapturedData[7:4];
      end
      PULSE_HI: begin
        nextEnable = 1'b1;
        nextRs     = nextCapturedRs;
        nextData   = nextCapturedData[7:4];
      end
      // The bus keeps holding the lower nibble during WAIT, so it does not toggle.
      SETUP_LO, HOLD_LO, WAIT: begin
        nextRs   = nextCapturedRs;
        nextData = nextCapturedData[3:0];
      end
      PULSE_LO: begin
        nextEnable = 1'b1;
        nextRs     = nextCapturedRs;
        nextData   = nextCapturedData[3:0];
      end
      default: begin
        nextReady = 1'b1;
      end
    endcase
  end

  // State, counter, capture and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state               <= IDLE;
      count               <= 32'd0;
      capturedData        <= 8'h00;
      capturedRs          <= 1'b0;
      capturedLong        <= 1'b0;
      oReady              <= 1'b1;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      state               <= nextState;
      count               <= nextCount;
      capturedData        <= nextCapturedData;
      capturedRs          <= nextCapturedRs;
      capturedLong        <= nextCapturedLong;
      oReady              <= nextReady;
      oDone               <= nextDone;
      oLCD_Enabled        <= nextEnable;
      oLCD_RegisterSelect <= nextRs;
      oLCD_Data           <= nextData;
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_byte_writer
//
// Self-checking bench for lcd_byte_writer. A timeline model gives the
// expected pin values for every cycle after an accept. It works from the
// documented durations: setup, strobe, hold, gap, setup, strobe, hold, then
// the settle wait. Byte values, register select, wait length and noise on
// the request inputs while busy are randomized.
// The long wait is shortened here to keep run time low.
// -----------------------------------------------------------------------------
module tb_lcd_byte_writer;

  localparam int SETUP  = 2;
  localparam int ENABLE = 12;
  localparam int GAP    = 50;
  localparam int CMDW   = 2000;
  localparam int LONGW  = 6000;

  // Offsets (edges after the accept edge) of the key moments of a byte.
  localparam int LO_START = SETUP + ENABLE + 1 + GAP;  // first lower-nibble cycle
  localparam int LO_RISE  = LO_START + SETUP;          // second E rising edge
  localparam int HOLD_END = LO_RISE + ENABLE + 1;      // first WAIT cycle

  logic       Clock;
  logic       Reset;
  logic       iWrite;
  logic       iRegisterSelect;
  logic [7:0] iData;
  logic       iLongWait;
  logic       oReady;
  logic       oDone;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic [3:0] oLCD_Data;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;

  int passCount  = 0;
  int checkCount = 0;

  lcd_byte_writer #(
    .SETUP_CYCLES      (SETUP),
    .ENABLE_CYCLES     (ENABLE),
    .NIBBLE_GAP_CYCLES (GAP),
    .CMD_WAIT_CYCLES   (CMDW),
    .LONG_WAIT_CYCLES  (LONGW)
  ) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .iWrite                  (iWrite),
    .iRegisterSelect         (iRegisterSelect),
    .iData                   (iData),
    .iLongWait               (iLongWait),
    .oReady                  (oReady),
    .oDone                   (oDone),
    .oLCD_Enabled            (oLCD_Enabled),
    .oLCD_RegisterSelect     (oLCD_RegisterSelect),
    .oLCD_Data               (oLCD_Data),
    .oLCD_ReadWrite          (oLCD_ReadWrite),
    .oLCD_StrataFlashControl (oLCD_StrataFlashControl)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Bus packing: {ready, done, E, RS, data[3:0]}
  function automatic logic [7:0] observedBus();
    return {oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data};
  endfunction

  function automatic int doneOffset(input logic lw);
    return HOLD_END + (lw ? LONGW : CMDW);
  endfunction

  // Expected pins t edges after the accept edge of byte d.
  function automatic logic [7:0] expectedBus(input int t, input logic [7:0] d, input logic rs, input logic lw);
    logic       e;
    logic [3:0] nib;
    if (t >= doneOffset(lw)) return 8'hC0;  // ready + done, bus idle
    e   = ((t >= SETUP) && (t < SETUP + ENABLE)) || ((t >= LO_RISE) && (t < LO_RISE + ENABLE));
    nib = (t < LO_START) ? d[7:4] : d[3:0];
    return {1'b0, 1'b0, e, rs, nib};
  endfunction

  // Idle cycles with no request. The block must sit ready with the bus low.
  task automatic idleCycles(input int n);
    iWrite = 1'b0;
    for (int i = 0; i < n; i++) begin
      iData = 8'($urandom);
      @(posedge Clock);
      @(negedge Clock);
      checkValue("idle", {8'd0, observedBus()}, {8'd0, 8'h80});
    end
  endtask

  // Issue a byte from a negedge with the block ready and follow it cycle by
  // cycle. busyMode: 0 quiet, 1 pulse at edge 500 and hold iWrite into the done
  // cycle, 2 random iWrite. abortAt >= 0 asserts Reset at that offset.
  task automatic sendByte(input logic [7:0] d, input logic rs, input logic lw,
                          input int busyMode, input int abortAt);
    int doneAt;
    logic [7:0] exp;
    logic [7:0] obs;
    doneAt          = doneOffset(lw);
    iWrite          = 1'b1;
    iData           = d;
    iRegisterSelect = rs;
    iLongWait       = lw;
    @(posedge Clock);
    for (int t = 0; t <= doneAt; t++) begin
      @(negedge Clock);
      exp = expectedBus(t, d, rs, lw);
      obs = observedBus();
      if (t >= HOLD_END && t < doneAt) begin
        checkValue("waitBus", {13'd0, obs[7:5]}, {13'd0, exp[7:5]});
      end else begin
        checkValue("bus", {8'd0, obs}, {8'd0, exp});
      end
      if (t == abortAt) begin
        Reset = 1'b0;
        #1;
        checkValue("abortAsync", {8'd0, observedBus()}, {8'd0, 8'h80});
        @(negedge Clock);
        checkValue("abortHeld", {8'd0, observedBus()}, {8'd0, 8'h80});
        Reset = 1'b1;
        return;
      end
      if (t < doneAt) begin
        iData           = 8'($urandom);
        iRegisterSelect = 1'($urandom);
        iLongWait       = 1'($urandom);
        case (busyMode)
          1:       iWrite = (t == 499) || (t >= doneAt - 5);
          2:       iWrite = 1'($urandom);
          default: iWrite = 1'b0;
        endcase
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       rs;
    logic       lw;
    Reset           = 1'b0;
    iWrite          = 1'b0;
    iData           = 8'h00;
    iRegisterSelect = 1'b0;
    iLongWait       = 1'b0;
    #12;
    checkValue("resetBus", {8'd0, observedBus()}, {8'd0, 8'h80});
    checkValue("readWrite", {15'd0, oLCD_ReadWrite}, 16'd0);
    checkValue("strataFlash", {15'd0, oLCD_StrataFlashControl}, 16'd1);
    @(negedge Clock);
    Reset = 1'b1;
    idleCycles(2);

    sendByte(8'h28, 1'b0, 1'b0, 0, -1);      // command, short wait
    idleCycles(2);
    sendByte(8'h41, 1'b1, 1'b0, 0, -1);      // data write
    idleCycles(1);
    sendByte(8'h01, 1'b0, 1'b1, 0, -1);      // clear: long wait
    idleCycles(1);
    sendByte(8'hA5, 1'b1, 1'b0, 1, -1);      // busy pulse ignored, iWrite held
    sendByte(8'h3C, 1'b0, 1'b0, 0, -1);      // accepted in the done cycle
    idleCycles(1);
    sendByte(8'h96, 1'b1, 1'b0, 0, LO_RISE + 3);  // reset during PULSE_LO
    sendByte(8'h5A, 1'b1, 1'b0, 0, -1);      // first edge after release
    idleCycles(2);

    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      rs = 1'($urandom);
      lw = ($urandom_range(3, 0) == 0);
      sendByte(d, rs, lw, 2, -1);
      idleCycles($urandom_range(2, 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter SETUP_CYCLES, default 2, sets the data/RS setup time before the LCD_E rising edge (40 ns at 50 MHz).
REQ-002 Parameter ENABLE_CYCLES, default 12, sets the LCD_E high width in cycles.
REQ-003 Parameter NIBBLE_GAP_CYCLES, default 50, sets the gap between the upper- and lower-nibble transfers (1 us).
REQ-004 Parameter CMD_WAIT_CYCLES, default 2000, sets the post-byte wait (40 us).
REQ-005 Parameter LONG_WAIT_CYCLES, default 82000, sets the post-byte wait for clear/home (1.64 ms).
REQ-006 Port Clock, input, 1 bit, is the single system clock; all state changes on its rising edge.
REQ-007 Port Reset, input, 1 bit, is the reset: asynchronous, active-low.
REQ-008 Port iWrite, input, 1 bit, is the byte-transfer request.
REQ-009 Port iRegisterSelect, input, 1 bit, selects the register: 0=command, 1=data.
REQ-010 Port iData, input, 8 bits, is the byte to send.
REQ-011 Port iLongWait, input, 1 bit, selects LONG_WAIT_CYCLES instead of CMD_WAIT_CYCLES for this byte.
REQ-012 Port oReady, output, 1 bit, is high when a request can be accepted.
REQ-013 Port oDone, output, 1 bit, is a one-cycle pulse when the byte and its wait are complete.
REQ-014 Port oLCD_Enabled, output, 1 bit, is the LCD_E strobe.
REQ-015 Port oLCD_RegisterSelect, output, 1 bit, is LCD_RS.
REQ-016 Port oLCD_Data, output, 4 bits, is SF_D<11:8>.
REQ-017 Port oLCD_ReadWrite, output, 1 bit, is constant 0 (write only).
REQ-018 Port oLCD_StrataFlashControl, output, 1 bit, is constant 1 (StrataFlash disabled).

Function
REQ-019 The FSM SHALL use states IDLE, SETUP_HI, PULSE_HI, HOLD_HI, GAP, SETUP_LO, PULSE_LO, HOLD_LO, WAIT; all outputs are registered.
REQ-020 oReady SHALL be 1 only in IDLE; a request is accepted on the edge where iWrite=1 and oReady=1, capturing iData, iRegisterSelect and iLongWait into internal registers.
REQ-021 On the accept edge, IDLE SHALL go to SETUP_HI; iWrite while not IDLE SHALL be ignored, with no queuing.
REQ-022 A 32-bit cycle counter SHALL clear on every state change; each timed state lasts exactly its parameter count of cycles.
REQ-023 SETUP_HI (SETUP_CYCLES) SHALL drive oLCD_Data=captured[7:4] and RS=captured RS, with E=0.
REQ-024 PULSE_HI (ENABLE_CYCLES) SHALL drive E=1 with the same data.
REQ-025 HOLD_HI (1 cycle) SHALL drive E=0 with the data held.
REQ-026 GAP (NIBBLE_GAP_CYCLES) SHALL drive E=0 with the data held.
REQ-027 SETUP_LO, PULSE_LO and HOLD_LO SHALL repeat SETUP_HI, PULSE_HI and HOLD_HI using captured[3:0].
REQ-028 WAIT SHALL last LONG_WAIT_CYCLES if captured iLongWait=1, else CMD_WAIT_CYCLES, with E=0, then go to IDLE.
REQ-029 oDone SHALL be 1 for exactly the first IDLE cycle after WAIT, and 0 otherwise.
REQ-030 oDone SHALL rise 80+W edges after the accept edge with default parameters (W = selected wait).
REQ-031 A new request SHALL be acceptable in the same cycle oDone=1 (back-to-back).
REQ-032 In IDLE, the block SHALL drive E=0, oLCD_Data=4'h0 and RS=0.
REQ-033 E SHALL never be high outside PULSE_HI/PULSE_LO.
REQ-034 Data and RS SHALL be stable from the start of SETUP through the end of HOLD.
REQ-035 Input changes after acceptance SHALL have no effect on the byte in flight.

Reset
REQ-036 Reset=0 SHALL immediately (asynchronously) force state IDLE, counter 0, captured registers 0, oLCD_Enabled=0, oLCD_Data=4'h0, oLCD_RegisterSelect=0, oDone=0 and oReady=1.
REQ-037 Reset asserted mid-transfer SHALL abort the byte with no oDone.
REQ-038 After Reset releases, the first rising edge SHALL be able to accept a request.

Verification
REQ-039 Command write: iData=8'h28, RS=0, iLongWait=0 -> E high for exactly 12 cycles with data 0x2, then 12 cycles with data 0x8; E rising edges are 65 cycles apart; RS=0 throughout; oDone at edge 2080.
REQ-040 Data write: iData=8'h41, RS=1 -> nibbles 0x4 then 0x1; RS=1 from SETUP_HI through HOLD_LO; oDone at edge 2080.
REQ-041 Long wait: iData=8'h01, iLongWait=1 -> oDone at edge 82080; no oDone at edge 2080.
REQ-042 Busy/back-to-back: iWrite pulsed at edge 500 -> ignored; iWrite held high through oDone -> second byte accepted in the oDone cycle, with its SETUP_HI on the next cycle.
REQ-043 Reset mid-transfer: Reset=0 during PULSE_LO -> E drops to 0 before the next clock edge; oReady=1; no oDone; the next request completes normally.
REQ-044 Assertion check across all tests: E is high only in PULSE states, each E pulse is exactly ENABLE_CYCLES wide, and oDone is never wider than one cycle.
